// File: rtl/pipelined_subtractor_pkg.sv
// Shared types and helpers for the sliced, pipelined subtractor.
package pipelined_subtractor_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  // hi is the more significant span, lo the less significant one
  function automatic gp_t gp_combine(input gp_t hi, input gp_t lo);
    gp_t r;
    r.g = hi.g | (hi.p & lo.g);
    r.p = hi.p & lo.p;
    return r;
  endfunction

endpackage

// File: rtl/sub_prefix_chunk.sv
// One CHUNK-bit subtract slice; borrows resolved by a Kogge-Stone prefix network.
module sub_prefix_chunk
  import pipelined_subtractor_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             b_in,
  output logic [CHUNK-1:0] d,
  output logic             b_out
);

  localparam int LEVELS = (CHUNK > 1) ? $clog2(CHUNK) : 0;

  gp_t [CHUNK-1:0] lvl [LEVELS+1];
  logic [CHUNK:0]  bor;

  for (genvar i = 0; i < CHUNK; i++) begin : g_leaf
    assign lvl[0][i] = '{g: ~x[i] & y[i], p: ~(x[i] ^ y[i])};
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
      if (i >= (1 << l)) begin : g_comb
        assign lvl[l+1][i] = gp_combine(lvl[l][i], lvl[l][i-(1<<l)]);
      end else begin : g_pass
        assign lvl[l+1][i] = lvl[l][i];
      end
    end
  end

  // bor[i] is the borrow into bit i; prefix over [i-1:0] folded with b_in
  assign bor[0] = b_in;
  for (genvar i = 0; i < CHUNK; i++) begin : g_bor
    assign bor[i+1] = lvl[LEVELS][i].g | (lvl[LEVELS][i].p & b_in);
  end

  assign d     = x ^ y ^ bor[CHUNK-1:0];
  assign b_out = bor[CHUNK];

endmodule

// File: rtl/pipelined_subtractor.sv
// W-bit subtractor, one CHUNK slice per stage, registered inter-slice borrow, valid/ready stall.
module pipelined_subtractor
  import pipelined_subtractor_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int STAGES = stages(WIDTH, CHUNK);

  if (WIDTH % CHUNK != 0) begin : g_bad_width
    $error("WIDTH must be a multiple of CHUNK");
  end

  logic              adv;
  logic [STAGES:1]   vld_pipe;

  assign out_valid = vld_pipe[STAGES];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe <= '0;
    end else if (adv) begin
      vld_pipe[1] <= in_valid;
      for (int i = 2; i <= STAGES; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  // Stage k holds diff bits [DW-1:0] (de-skew) and operand bits above DW (skew)
  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int DW = (k + 1) * CHUNK;

    logic [CHUNK-1:0] xs, ys, ds;
    logic             bi, bo;
    logic [DW-1:0]    d_nx, d_q;
    logic             b_q;

    if (k == 0) begin : g_src
      assign xs   = x[CHUNK-1:0];
      assign ys   = y[CHUNK-1:0];
      assign bi   = borrow_in;
      assign d_nx = ds;
    end else begin : g_src
      assign xs   = g_stg[k-1].g_ops.x_q[CHUNK-1:0];
      assign ys   = g_stg[k-1].g_ops.y_q[CHUNK-1:0];
      assign bi   = g_stg[k-1].b_q;
      assign d_nx = {ds, g_stg[k-1].d_q};
    end

    sub_prefix_chunk #(.CHUNK(CHUNK)) u_chunk (
      .x     (xs),
      .y     (ys),
      .b_in  (bi),
      .d     (ds),
      .b_out (bo)
    );

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        d_q <= '0;
        b_q <= 1'b0;
      end else if (adv) begin
        d_q <= d_nx;
        b_q <= bo;
      end
    end

    if (k < STAGES - 1) begin : g_ops
      localparam int OW = WIDTH - DW;
      logic [OW-1:0] x_nx, y_nx, x_q, y_q;

      if (k == 0) begin : g_in
        assign x_nx = x[WIDTH-1:CHUNK];
        assign y_nx = y[WIDTH-1:CHUNK];
      end else begin : g_in
        assign x_nx = g_stg[k-1].g_ops.x_q[OW+CHUNK-1:CHUNK];
        assign y_nx = g_stg[k-1].g_ops.y_q[OW+CHUNK-1:CHUNK];
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          x_q <= '0;
          y_q <= '0;
        end else if (adv) begin
          x_q <= x_nx;
          y_q <= y_nx;
        end
      end
    end
  end

  assign diff       = g_stg[STAGES-1].d_q;
  assign borrow_out = g_stg[STAGES-1].b_q;

endmodule
